// File: rtl/signal_conditioner.sv
// Synchronise, deglitch and prescale a raw input; level_out/edge_pulse lag signal_in by SYNC_STAGES+filter_q+2 cycles.
// No backpressure: edge_pulse is a registered 1-cycle strobe and is never asserted in adjacent cycles.
module signal_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_BITS    = 4,
  parameter int PRESCALE_BITS  = 4,
  parameter int FILTER_DEFAULT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     signal_in,
  input  logic                     cfg_load,
  input  logic [FILTER_BITS-1:0]   filter_len,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic                     level_out,
  output logic                     edge_pulse,
  output logic [7:0]               glitch_cnt
);

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [FILTER_BITS-1:0]   cnt_q, cnt_d;
  logic [FILTER_BITS-1:0]   filter_q, filter_d;
  logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
  logic                     level_d, pulse_d;
  logic [7:0]               glitch_d;
  logic                     s, abort, rise;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      state_q    <= LOW;
      cnt_q      <= '0;
      pre_cnt_q  <= '0;
      filter_q   <= FILTER_BITS'(FILTER_DEFAULT);
      prescale_q <= '0;
      level_out  <= 1'b0;
      edge_pulse <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], signal_in};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      filter_q   <= filter_d;
      prescale_q <= prescale_d;
      level_out  <= level_d;
      edge_pulse <= pulse_d;
      glitch_cnt <= glitch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_cnt_d  = pre_cnt_q;
    filter_d   = filter_q;
    prescale_d = prescale_q;
    level_d    = level_out;
    pulse_d    = 1'b0;
    glitch_d   = glitch_cnt;
    abort      = 1'b0;
    rise       = 1'b0;

    if (cfg_load) begin
      // A pending transition is dropped silently; the accepted level stands.
      filter_d   = filter_len;
      prescale_d = prescale;
      cnt_d      = '0;
      pre_cnt_d  = '0;
      glitch_d   = 8'd0;
      state_d    = level_out ? HIGH : LOW;
    end else begin
      unique case (state_q)
        LOW: begin
          if (s) begin
            state_d = RISE_WAIT;
            cnt_d   = '0;
          end
        end
        RISE_WAIT: begin
          if (!s) begin
            state_d = LOW;
            abort   = 1'b1;
          end else if (cnt_q == filter_q) begin
            state_d = HIGH;
            level_d = 1'b1;
            rise    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HIGH: begin
          if (!s) begin
            state_d = FALL_WAIT;
            cnt_d   = '0;
          end
        end
        FALL_WAIT: begin
          if (s) begin
            state_d = HIGH;
            abort   = 1'b1;
          end else if (cnt_q == filter_q) begin
            state_d = LOW;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = LOW;
      endcase

      if (abort && glitch_cnt != 8'd255) glitch_d = glitch_cnt + 8'd1;

      if (rise) begin
        if (pre_cnt_q == prescale_q) begin
          pulse_d   = 1'b1;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_signal_conditioner.sv
// Directed and randomized checks of signal_conditioner against a run-length reference model.
module tb_signal_conditioner;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       signal_in;
  logic       cfg_load;
  logic [3:0] filter_len;
  logic [3:0] prescale;
  logic       level_out;
  logic       edge_pulse;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: the accepted level, the length of the current run
  // of opposite samples, and plain counts of rises and rejected runs.
  logic [SYNC-1:0] m_sync;
  bit              m_lvl, m_pulse;
  int              m_run, m_fq, m_pq, m_rises, m_glitch;

  always #5 clk = ~clk;

  signal_conditioner #(
    .SYNC_STAGES(SYNC), .FILTER_BITS(4), .PRESCALE_BITS(4), .FILTER_DEFAULT(3)
  ) dut (
    .clk(clk), .reset(reset), .signal_in(signal_in), .cfg_load(cfg_load),
    .filter_len(filter_len), .prescale(prescale),
    .level_out(level_out), .edge_pulse(edge_pulse), .glitch_cnt(glitch_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit s;
    if (reset) begin
      m_sync = '0; m_lvl = 0; m_run = 0; m_fq = 3; m_pq = 0;
      m_rises = 0; m_glitch = 0; m_pulse = 0;
    end else begin
      s = m_sync[SYNC-1];
      m_sync = {m_sync[SYNC-2:0], signal_in};
      m_pulse = 0;
      if (cfg_load) begin
        m_fq = int'(filter_len); m_pq = int'(prescale);
        m_run = 0; m_rises = 0; m_glitch = 0;
      end else if (s != m_lvl) begin
        m_run++;
        if (m_run == m_fq + 2) begin
          m_lvl = s;
          m_run = 0;
          if (s) begin
            m_rises++;
            if (m_rises % (m_pq + 1) == 0) m_pulse = 1;
          end
        end
      end else if (m_run > 0) begin
        if (m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("level_out", int'(level_out), int'(m_lvl));
    chk("edge_pulse", int'(edge_pulse), int'(m_pulse));
    chk("glitch_cnt", int'(glitch_cnt), m_glitch);
  endtask

  task automatic drive(input bit v, input int n);
    signal_in = v;
    repeat (n) step();
  endtask

  task automatic do_reset(input bit v);
    reset = 1'b1; signal_in = v;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Holds the current input and reports the cycle (1-based) of the first level_out rise.
  task automatic measure_rise(output int cyc, output bit pulse_at_rise);
    cyc = -1; pulse_at_rise = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (level_out && cyc < 0) begin
        cyc = c; pulse_at_rise = edge_pulse;
      end
    end
  endtask

  initial begin
    int  cyc, pulses, rises_seen, any_hi;
    bit  p;

    reset = 1'b1; signal_in = 1'b0; cfg_load = 1'b0; filter_len = '0; prescale = '0;

    // 1: reset with input held high, then first rise timing
    do_reset(1'b1);
    chk("reset_level", int'(level_out), 0);
    chk("reset_glitch", int'(glitch_cnt), 0);
    measure_rise(cyc, p);
    chk("rise_latency", cyc, 7);
    chk("rise_pulse", int'(p), 1);

    // 2: short pulses rejected, a long one accepted, short low dip filtered
    do_reset(1'b0);
    drive(1'b0, 4);
    drive(1'b1, 1); drive(1'b0, 10);
    drive(1'b1, 3); drive(1'b0, 10);
    chk("glitch_two", int'(glitch_cnt), 2);
    chk("glitch_level", int'(level_out), 0);
    drive(1'b1, 10);
    chk("long_high", int'(level_out), 1);
    drive(1'b0, 3); drive(1'b1, 6);
    chk("dip_filtered", int'(level_out), 1);
    chk("dip_glitch", int'(glitch_cnt), 3);
    drive(1'b0, 10);
    chk("long_low", int'(level_out), 0);

    // 3: divide-by-5 over 12 clean periods
    signal_in = 1'b0; cfg_load = 1'b1; filter_len = 4'd0; prescale = 4'd4;
    step();
    cfg_load = 1'b0;
    drive(1'b0, 8);
    pulses = 0; rises_seen = 0;
    for (int i = 0; i < 12; i++) begin
      signal_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
        step();
        if (edge_pulse) begin
          pulses++;
          chk("pulse_on_rise", rises_seen + 1, (rises_seen + 1 <= 5) ? 5 : 10);
        end
        if (level_out && k == 7) rises_seen++;
      end
      drive(1'b0, 8);
    end
    chk("pulse_total", pulses, 2);
    chk("rises_total", rises_seen, 12);

    // 4: glitch counter saturation
    do_reset(1'b0);
    drive(1'b0, 4);
    any_hi = 0;
    for (int i = 0; i < 300; i++) begin
      signal_in = 1'b1; step();
      if (level_out || edge_pulse) any_hi++;
      signal_in = 1'b0; step(); step();
      if (level_out || edge_pulse) any_hi++;
    end
    drive(1'b0, 5);
    chk("glitch_sat", int'(glitch_cnt), 255);
    chk("glitch_quiet", any_hi, 0);

    // 5: cfg_load lands on the cycle a RISE_WAIT would abort
    drive(1'b1, 3);
    drive(1'b0, 2);
    cfg_load = 1'b1; filter_len = 4'd3; prescale = 4'd0;
    step();
    cfg_load = 1'b0;
    chk("cfg_glitch", int'(glitch_cnt), 0);
    chk("cfg_edge", int'(edge_pulse), 0);
    drive(1'b0, 6);
    chk("cfg_glitch_after", int'(glitch_cnt), 0);
    chk("cfg_level", int'(level_out), 0);

    // 6: reset during FALL_WAIT restores defaults
    cfg_load = 1'b1; filter_len = 4'd6; prescale = 4'd1;
    step();
    cfg_load = 1'b0;
    drive(1'b1, 14);
    chk("pre_high", int'(level_out), 1);
    drive(1'b0, 4);
    chk("fallwait_level", int'(level_out), 1);
    reset = 1'b1; signal_in = 1'b1;
    step();
    chk("rst_mid_level", int'(level_out), 0);
    chk("rst_mid_edge", int'(edge_pulse), 0);
    reset = 1'b0;
    measure_rise(cyc, p);
    chk("rst_mid_latency", cyc, 7);
    chk("rst_mid_pulse", int'(p), 1);

    // 7: randomized runs with occasional reconfiguration and reset
    for (int r = 0; r < 400; r++) begin
      int len;
      len = $urandom_range(1, 9);
      signal_in = ~signal_in;
      for (int k = 0; k < len; k++) begin
        cfg_load = ($urandom_range(0, 40) == 0);
        reset    = ($urandom_range(0, 250) == 0);
        if (cfg_load) begin
          filter_len = 4'($urandom_range(0, 4));
          prescale   = 4'($urandom_range(0, 3));
        end
        step();
        cfg_load = 1'b0;
        reset    = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
